// File: rtl/prco_mem_arbiter.sv
// rtl/prco_mem_arbiter.sv - single-port memory arbiter between instruction fetch and data accesses
module prco_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_fetch_req,
  input  logic [15:0] i_fetch_addr,
  input  logic        i_flush,
  input  logic        i_data_req,
  input  logic        i_data_we,
  input  logic [15:0] i_data_addr,
  input  logic [15:0] i_data_wdata,
  output logic        q_fetch_gnt,
  output logic        q_data_gnt,
  output logic        q_fetch_valid,
  output logic        q_data_valid,
  output logic [15:0] q_fetch_data,
  output logic [15:0] q_data_rdata,
  output logic        q_mem_en,
  output logic        q_mem_we,
  output logic [15:0] q_mem_addr,
  output logic [15:0] q_mem_dina,
  input  logic [15:0] i_mem_douta,
  output logic        q_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // One extra bit so the counter can reach STARVE_LIMIT without wrapping.
  localparam int CW = $clog2(STARVE_LIMIT + 1) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [1:0]    state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          id_q, id_d;          // 1 = data access, 0 = fetch access
  logic          flush_q, flush_d;    // sticky: fetch response discarded
  logic [CW-1:0] starve_q, starve_d;
  logic [15:0]   fetch_data_q, fetch_data_d;
  logic [15:0]   data_rdata_q, data_rdata_d;

  logic pick_fetch;
  logic in_issue;
  logic in_done;

  assign in_issue = (state_q == S_ISSUE);
  assign in_done  = (state_q == S_DONE);

  // Fetch wins only when data is idle or data has already had its limit of grants.
  assign pick_fetch = i_fetch_req && (!i_data_req || (starve_q >= LIMIT));

  // Next-state, request latching and read-data capture.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    id_d         = id_q;
    flush_d      = flush_q;
    fetch_data_d = fetch_data_q;
    data_rdata_d = data_rdata_q;
    case (state_q)
      S_IDLE: begin
        flush_d = 1'b0;
        if (i_fetch_req || i_data_req) begin
          state_d = S_ISSUE;
          id_d    = !pick_fetch;
          if (pick_fetch) begin
            addr_d  = i_fetch_addr;
            we_d    = 1'b0;
            wdata_d = 16'h0000;
          end else begin
            addr_d  = i_data_addr;
            we_d    = i_data_we;
            wdata_d = i_data_wdata;
          end
        end
      end
      S_ISSUE: begin
        flush_d = flush_q | i_flush;
        state_d = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        flush_d = flush_q | i_flush;
        state_d = S_DONE;
        if (id_q) begin
          data_rdata_d = i_mem_douta;
        end else if (!flush_q && !i_flush) begin
          fetch_data_d = i_mem_douta;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Starvation counter: counts data grants while fetch waits, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!i_fetch_req) begin
      starve_d = '0;
    end else if (in_issue && !id_q) begin
      starve_d = '0;
    end else if (in_issue && id_q && (starve_q < LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      id_q         <= 1'b0;
      flush_q      <= 1'b0;
      starve_q     <= '0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      id_q         <= id_d;
      flush_q      <= flush_d;
      starve_q     <= starve_d;
      fetch_data_q <= fetch_data_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Memory port and handshake outputs are pure state decodes; a flush seen in
  // the DONE cycle itself still suppresses the fetch completion.
  assign q_mem_en      = in_issue;
  assign q_mem_we      = in_issue & we_q;
  assign q_mem_addr    = in_issue ? addr_q : 16'h0000;
  assign q_mem_dina    = in_issue ? wdata_q : 16'h0000;
  assign q_fetch_gnt   = in_issue & ~id_q;
  assign q_data_gnt    = in_issue & id_q;
  assign q_fetch_valid = in_done & ~id_q & ~flush_q & ~i_flush;
  assign q_data_valid  = in_done & id_q;
  assign q_fetch_data  = fetch_data_q;
  assign q_data_rdata  = data_rdata_q;
  assign q_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_prco_mem_arbiter.sv
// tb/tb_prco_mem_arbiter.sv - directed self-checking bench for prco_mem_arbiter
module tb_prco_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        flush;
  logic        data_req;
  logic        data_we;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;
  logic        fetch_gnt, data_gnt, fetch_valid, data_valid;
  logic [15:0] fetch_data, data_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_dina;
  logic [15:0] mem_douta;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:1023];
  int          seq [0:9];
  int          ng;

  prco_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_fetch_req  (fetch_req),
    .i_fetch_addr (fetch_addr),
    .i_flush      (flush),
    .i_data_req   (data_req),
    .i_data_we    (data_we),
    .i_data_addr  (data_addr),
    .i_data_wdata (data_wdata),
    .q_fetch_gnt  (fetch_gnt),
    .q_data_gnt   (data_gnt),
    .q_fetch_valid(fetch_valid),
    .q_data_valid (data_valid),
    .q_fetch_data (fetch_data),
    .q_data_rdata (data_rdata),
    .q_mem_en     (mem_en),
    .q_mem_we     (mem_we),
    .q_mem_addr   (mem_addr),
    .q_mem_dina   (mem_dina),
    .i_mem_douta  (mem_douta),
    .q_busy       (busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read, read-first memory model.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_douta <= mem[mem_addr[9:0]];
      if (mem_we) mem[mem_addr[9:0]] <= mem_dina;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0020] = 16'h5555;
    mem_douta  = 16'h0000;
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = 16'h0000;
    flush      = 1'b0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = 16'h0000;
    data_wdata = 16'h0000;
    tick();
    tick();

    // Reset state
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_mem_en", 16'(mem_en), 16'd0);
    check("rst_fetch_data", fetch_data, 16'h0000);
    reset = 1'b0;
    tick();

    // Fetch read of 0x0010
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    tick();
    check("f_gnt", 16'(fetch_gnt), 16'd1);
    check("f_mem_en", 16'(mem_en), 16'd1);
    check("f_mem_addr", mem_addr, 16'h0010);
    check("f_mem_we", 16'(mem_we), 16'd0);
    fetch_req = 1'b0;
    tick();
    check("f_wait_valid", 16'(fetch_valid), 16'd0);
    tick();
    check("f_valid", 16'(fetch_valid), 16'd1);
    check("f_data", fetch_data, 16'hBEEF);
    tick();
    check("f_idle_busy", 16'(busy), 16'd0);

    // Store 0x1234 to 0x0200; input change after grant must not leak through
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0200; data_wdata = 16'h1234;
    tick();
    check("s_gnt", 16'(data_gnt), 16'd1);
    data_addr = 16'h0333; data_wdata = 16'hDEAD; data_req = 1'b0;
    #1;
    check("s_mem_we", 16'(mem_we), 16'd1);
    check("s_mem_addr", mem_addr, 16'h0200);
    check("s_mem_dina", mem_dina, 16'h1234);
    tick();
    check("s_valid", 16'(data_valid), 16'd1);
    check("s_done_we", 16'(mem_we), 16'd0);
    tick();
    check("s_idle_busy", 16'(busy), 16'd0);

    // Load back 0x0200
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0200;
    tick();
    check("l_gnt", 16'(data_gnt), 16'd1);
    check("l_mem_we", 16'(mem_we), 16'd0);
    data_req = 1'b0;
    tick();
    tick();
    check("l_valid", 16'(data_valid), 16'd1);
    check("l_rdata", data_rdata, 16'h1234);
    tick();

    // Simultaneous requests: data first, then fetch on the next IDLE edge
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0200;
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    tick();
    check("sim_data_gnt", 16'(data_gnt), 16'd1);
    check("sim_fetch_gnt0", 16'(fetch_gnt), 16'd0);
    data_req = 1'b0;
    tick();
    tick();
    tick();
    check("sim_idle_fetch_gnt", 16'(fetch_gnt), 16'd0);
    tick();
    check("sim_fetch_gnt1", 16'(fetch_gnt), 16'd1);
    fetch_req = 1'b0;
    tick();
    tick();
    tick();

    // Starvation: data stores held with fetch held -> D D D D F D D D D F
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0300; data_wdata = 16'hA5A5;
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    ng = 0;
    for (int c = 0; c < 48 && ng < 10; c++) begin
      tick();
      if (fetch_gnt) begin
        check("starve_fetch_we", 16'(mem_we), 16'd0);
        seq[ng] = 0;
        ng++;
      end else if (data_gnt) begin
        seq[ng] = 1;
        ng++;
      end
    end
    check("starve_ngrants", 16'(ng), 16'd10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("starve_seq%0d", k), 16'(seq[k]), ((k == 4) || (k == 9)) ? 16'd0 : 16'd1);
    end
    data_req = 1'b0; fetch_req = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("starve_fetch_data", fetch_data, 16'hBEEF);

    // Flush during WAIT of a fetch
    fetch_req = 1'b1; fetch_addr = 16'h0020;
    tick();
    check("fl_gnt", 16'(fetch_gnt), 16'd1);
    fetch_req = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("fl_valid", 16'(fetch_valid), 16'd0);
    check("fl_busy_done", 16'(busy), 16'd1);
    check("fl_data_kept", fetch_data, 16'hBEEF);
    tick();
    check("fl_busy_idle", 16'(busy), 16'd0);

    // Flush has no effect on a data load
    flush = 1'b1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0200;
    tick();
    data_req = 1'b0;
    tick();
    tick();
    check("fl_data_valid", 16'(data_valid), 16'd1);
    check("fl_data_rdata", data_rdata, 16'h1234);
    flush = 1'b0;
    tick();

    // Reset during WAIT of a load
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0010;
    tick();
    data_req = 1'b0;
    tick();
    reset = 1'b1; fetch_req = 1'b1; flush = 1'b1;
    tick();
    check("rw_busy", 16'(busy), 16'd0);
    check("rw_data_valid", 16'(data_valid), 16'd0);
    check("rw_mem_en", 16'(mem_en), 16'd0);
    check("rw_data_rdata", data_rdata, 16'h0000);
    check("rw_fetch_data", fetch_data, 16'h0000);
    check("rw_fetch_gnt", 16'(fetch_gnt), 16'd0);
    reset = 1'b0; fetch_req = 1'b0; flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rw_after_valid", 16'(data_valid | data_gnt | fetch_gnt), 16'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
